vga_mem_arbiter: RTL and testbench

- Shares the single frame-memory read/write port between two requesters: VGA pixel fetch (Bitgen side) and CPU load/store.
- VGA has absolute priority while `bright`=1. CPU accesses are serviced only while `bright`=0.
- Sits between the VGA controller/Bitgen pair and port B of the frame block RAM.
- Returns registered fetch data to Bitgen and read data to the CPU, using a req/ack handshake.

---
 rtl/vga_mem_arbiter_if.sv | 41 ++++
 rtl/vga_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: bundles the arbiter's VGA, CPU and RAM-port signals.
// The slave modport is the arbiter's view; master is the surrounding
// environment (VGA controller, Bitgen, CPU and block RAM together).
// dbg_state mirrors the arbiter FSM (0 IDLE, 1 ISSUE, 2 RDWAIT, 3 ACK).
`timescale 1ns/1ps
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  // VGA / Bitgen side
  logic              bright;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_starve;
  // Block RAM port B
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  // FSM state for observation
  logic [1:0]        dbg_state;

  modport slave (
    input  bright, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    output vga_data, cpu_ack, cpu_rdata, cpu_starve,
    output mem_addr, mem_we, mem_din, dbg_state
  );

  modport master (
    output bright, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dout,
    input  vga_data, cpu_ack, cpu_rdata, cpu_starve,
    input  mem_addr, mem_we, mem_din, dbg_state
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one frame-RAM port between VGA pixel fetch and
// CPU load/store. VGA owns the port whenever bright=1; the CPU is served
// only during blanking. Optional starvation monitor is built when the
// macro VGA_MEM_ARB_STARVE_EN is defined; otherwise cpu_starve is tied 0.
//
// CPU handshake: cpu_req is a level held (with cpu_we/cpu_addr/cpu_wdata
// stable) until cpu_ack; cpu_ack is a registered one-cycle pulse, and for a
// read cpu_rdata is valid in that same cycle. Dropping cpu_req while the
// FSM is idle cancels the request; once issued the access always completes.
// While cpu_ack is high the FSM will not accept a new request, so a master
// that drops cpu_req on the edge after seeing the ack is never re-served.
`timescale 1ns/1ps
module vga_mem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int READ_LAT     = 1,    // block RAM read latency, 1..3
  parameter int STARVE_LIMIT = 1024
) (
  input  logic            clock,
  input  logic            clear,
  vga_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_cpu_owns;
  logic                w_cpu_tok_in;
  logic                w_cpu_tok_out;
  logic                w_vga_tok_out;
  logic [READ_LAT-1:0] r_vga_tok;
  logic [READ_LAT-1:0] r_cpu_tok;

  logic [DATA_W-1:0]   r_vga_data;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_cpu_ack;

  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_din;

  // The CPU drives the RAM only in its single ISSUE cycle, and only if the
  // display has not become active in that very cycle.
  assign w_cpu_owns    = (r_state == S_ISSUE) && !bus.bright;
  assign w_cpu_tok_in  = w_cpu_owns && !bus.cpu_we;
  assign w_cpu_tok_out = r_cpu_tok[READ_LAT-1];
  assign w_vga_tok_out = r_vga_tok[READ_LAT-1];

  // FSM state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_req && !bus.bright && !r_cpu_ack) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // Display went active during issue: abandon, retry from IDLE.
        if (bus.bright)      w_state_nxt = S_IDLE;
        else if (bus.cpu_we) w_state_nxt = S_ACK;
        else                 w_state_nxt = S_RDWAIT;
      end
      S_RDWAIT: begin
        // An issued read finishes regardless of later bright changes.
        if (w_cpu_tok_out) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port mux: VGA address by default, CPU access only when it owns the
  // port; forced to zero while clear is held.
  always_comb begin
    w_mem_addr = bus.vga_addr;
    w_mem_we   = 1'b0;
    w_mem_din  = '0;
    if (clear) begin
      w_mem_addr = '0;
    end else if (w_cpu_owns) begin
      w_mem_addr = bus.cpu_addr;
      w_mem_we   = bus.cpu_we;
      w_mem_din  = bus.cpu_wdata;
    end
  end

  // Read-token pipelines: one bit per cycle of RAM latency, marking which
  // returning words belong to VGA and which to a CPU read.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_vga_tok <= '0;
      r_cpu_tok <= '0;
    end else begin
      r_vga_tok[0] <= bus.bright;
      r_cpu_tok[0] <= w_cpu_tok_in;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vga_tok[i] <= r_vga_tok[i-1];
        r_cpu_tok[i] <= r_cpu_tok[i-1];
      end
    end
  end

  // Bitgen data register: load the RAM word when a VGA token exits.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)              r_vga_data <= '0;
    else if (w_vga_tok_out) r_vga_data <= bus.mem_dout;
  end

  // CPU read data: captured as the CPU token exits, held until next read.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                                      r_cpu_rdata <= '0;
    else if ((r_state == S_RDWAIT) && w_cpu_tok_out) r_cpu_rdata <= bus.mem_dout;
  end

  // Completion pulse: one cycle, registered from the ACK state.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_cpu_ack <= 1'b0;
    else       r_cpu_ack <= (r_state == S_ACK);
  end

`ifdef VGA_MEM_ARB_STARVE_EN
  localparam logic [15:0] LP_LIMIT = 16'(STARVE_LIMIT);

  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_starve;

  // Wait counter: counts idle cycles with a pending request, saturating.
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (r_state == S_ISSUE)
      w_wait_cnt_nxt = '0;
    else if ((r_state == S_IDLE) && bus.cpu_req && (r_wait_cnt != 16'hFFFF))
      w_wait_cnt_nxt = r_wait_cnt + 16'd1;
  end

  // Counter register and sticky starvation flag (cleared only by reset).
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_wait_cnt <= '0;
      r_starve   <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_wait_cnt_nxt >= LP_LIMIT) r_starve <= 1'b1;
    end
  end

  assign bus.cpu_starve = r_starve;
`else
  assign bus.cpu_starve = 1'b0;
`endif

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_din   = w_mem_din;
  assign bus.vga_data  = r_vga_data;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed bench for vga_mem_arbiter with a block RAM
// model (latency 1), an ack scoreboard and a port-activity monitor.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int RL = 1;
  localparam int SL = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .STARVE_LIMIT(SL)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en)       ram[pl_addr]      <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int ack_cnt  = 0;
  int we_cycles = 0;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  // bit DW: 1 = read (compare data), 0 = write
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each ack, watches RAM writes.
  always @(negedge clock) begin
    if (!clear) begin
      if (bus.mem_we) begin
        we_cycles++;
        we_addr = bus.mem_addr;
        we_data = bus.mem_din;
        check("we_while_bright", {31'd0, bus.bright}, 32'd0);
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_ack: got ack, want none (rdata %0h)", bus.cpu_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[DW]) check("cpu_rdata", {16'd0, bus.cpu_rdata}, {16'd0, mon_e[DW-1:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic cpu_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  // Counts rising edges until cpu_ack is seen; n = -1 on timeout.
  task automatic wait_ack(input int max_e, output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end while (!bus.cpu_ack && n < max_e);
    if (!bus.cpu_ack) n = -1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int n;
  int ack_before;
  int bad_we;
  int bad_addr;
  logic exp_starve;

  initial begin
    bus.bright    = 1'b0;
    bus.vga_addr  = 15'h1234;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
`ifdef VGA_MEM_ARB_STARVE_EN
    exp_starve = 1'b1;
`else
    exp_starve = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ack",     {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_mem_we",  {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
    check("rst_vga_data", {16'd0, bus.vga_data}, 32'd0);
    check("rst_state",   {30'd0, bus.dbg_state}, 32'd0);
    tick();
    clear = 1'b0;
    tick();

    // Blanking write
    we_cycles = 0;
    exp_q.push_back({1'b0, 16'hA5A5});
    cpu_drive(1'b1, 15'h4E84, 16'hA5A5);
    wait_ack(20, n);
    check("wr_latency", n, 32'd3);
    bus.cpu_req = 1'b0;
    check("wr_we_cycles", we_cycles, 32'd1);
    check("wr_addr", {17'd0, we_addr}, 32'h4E84);
    check("wr_data", {16'd0, we_data}, 32'hA5A5);
    tick();
    tick();
    check("wr_ram", {16'd0, ram[15'h4E84]}, 32'hA5A5);

    // Blanking read
    preload(15'h7ED4, 16'h1234);
    exp_q.push_back({1'b1, 16'h1234});
    cpu_drive(1'b0, 15'h7ED4, 16'h0000);
    wait_ack(20, n);
    check("rd_latency", n, 32'd4);
    bus.cpu_req = 1'b0;
    tick();

    // Read at the top address
    preload(15'h7FFF, 16'hBEEF);
    exp_q.push_back({1'b1, 16'hBEEF});
    cpu_drive(1'b0, 15'h7FFF, 16'h0000);
    wait_ack(20, n);
    check("rd_top_latency", n, 32'd4);
    bus.cpu_req = 1'b0;
    tick();

    // Display priority: write to address 0 held off for 640 cycles
    bus.bright = 1'b1;
    exp_q.push_back({1'b0, 16'h0F0F});
    cpu_drive(1'b1, 15'h0000, 16'h0F0F);
    ack_before = ack_cnt;
    bad_we = 0;
    bad_addr = 0;
    for (int i = 0; i < 640; i++) begin
      bus.vga_addr = AW'(i * 37 + 5);
      @(negedge clock);
      if (bus.mem_we !== 1'b0) bad_we++;
      if (bus.mem_addr !== bus.vga_addr) bad_addr++;
      tick();
    end
    check("prio_we", bad_we, 32'd0);
    check("prio_addr", bad_addr, 32'd0);
    check("prio_no_ack", ack_cnt - ack_before, 32'd0);
    bus.bright = 1'b0;
    wait_ack(20, n);
    check("prio_latency", n, 32'd3);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    check("prio_ram0", {16'd0, ram[15'h0000]}, 32'h0F0F);

    // Reset in the middle of a read
    cpu_drive(1'b0, 15'h7ED4, 16'h0000);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rdwait_state", {30'd0, bus.dbg_state}, 32'd2);
    #1;
    clear = 1'b1;
    #1;
    check("mid_ack",      {31'd0, bus.cpu_ack}, 32'd0);
    check("mid_mem_we",   {31'd0, bus.mem_we}, 32'd0);
    check("mid_mem_addr", {17'd0, bus.mem_addr}, 32'd0);
    check("mid_mem_din",  {16'd0, bus.mem_din}, 32'd0);
    check("mid_vga_data", {16'd0, bus.vga_data}, 32'd0);
    check("mid_cpu_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
    check("mid_starve",   {31'd0, bus.cpu_starve}, 32'd0);
    check("mid_state",    {30'd0, bus.dbg_state}, 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    clear = 1'b0;
    ack_before = ack_cnt;
    repeat (10) tick();
    check("post_rst_no_ack", ack_cnt - ack_before, 32'd0);
    check("post_rst_vga_data", {16'd0, bus.vga_data}, 32'd0);

    // VGA fetch: two consecutive addresses
    preload(15'h7ED4, 16'hFFFF);
    preload(15'h7ED5, 16'h0001);
    bus.bright   = 1'b1;
    bus.vga_addr = 15'h7ED4;
    tick();
    bus.vga_addr = 15'h7ED5;
    @(negedge clock);
    check("vga_edge1", {16'd0, bus.vga_data}, 32'h0000);
    tick();
    bus.vga_addr = 15'h0000;
    @(negedge clock);
    check("vga_first", {16'd0, bus.vga_data}, 32'hFFFF);
    @(negedge clock);
    check("vga_second", {16'd0, bus.vga_data}, 32'h0001);
    tick();

    // Starvation: request held under display for STARVE_LIMIT cycles
    cpu_drive(1'b0, 15'h7ED5, 16'h0000);
    for (int k = 1; k <= SL; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == SL - 1) check("starve_before", {31'd0, bus.cpu_starve}, 32'd0);
      if (k == SL)     check("starve_set", {31'd0, bus.cpu_starve}, {31'd0, exp_starve});
    end
    tick();
    bus.bright = 1'b0;
    exp_q.push_back({1'b1, 16'h0001});
    wait_ack(20, n);
    check("starve_rd_latency", n, 32'd4);
    bus.cpu_req = 1'b0;
    tick();
    check("starve_sticky", {31'd0, bus.cpu_starve}, {31'd0, exp_starve});
    clear = 1'b1;
    #1;
    check("starve_cleared", {31'd0, bus.cpu_starve}, 32'd0);
    tick();
    clear = 1'b0;
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
